uart_rx: RTL

- 8N1 UART receiver, LSB first: the receive end of the link driven by the existing UART transmitter.
- Oversamples the serial line at the system clock, CLKS_PER_BIT clocks per bit.
- Delivers each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the external RX pin and the command parser in the Sphere top level.

---
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, oversampled at the system clock.
//
// The raw serial line is brought into the clock domain through a two-stage
// synchronizer. A falling edge while idle starts a frame; the start bit is
// re-checked half a bit later so that short low glitches are rejected. Data
// bits and the stop bit are then sampled once per bit period, at mid-bit.
//
// Optional feature (macro UART_RX_MAJORITY_EN):
//   When defined, every sampling decision uses the 2-of-3 majority of a
//   three-deep history of the synchronized line. A single-clock glitch at a
//   sample point is therefore ignored. Idle edge detection always uses the
//   plain synchronized line. When undefined, no history register exists.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per bit, 8..255
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Rst_n      asynchronous active-low reset
//   i_RX_Serial  raw serial line, asynchronous, idles high
//   o_RX_DV      one-cycle strobe: o_RX_Byte valid
//   o_RX_Byte    last correctly framed byte, held until the next good byte
//   o_RX_Active  high from accepted start bit until return to idle
//   o_Frame_Err  one-cycle strobe: stop bit sampled low
//
// state         | meaning
// --------------+-----------------------------------------------------
// IDLE          | line idle, waiting for a low level on rx_s
// RX_START_BIT  | counting to mid start bit, then re-checking it
// RX_DATA_BITS  | sampling the eight data bits at mid-bit
// RX_STOP_BIT   | sampling the stop bit, issuing DV or framing error
// CLEANUP       | one cycle to drop o_RX_Active after a good frame
// WAIT_HIGH     | after a framing error, wait for the line to go high

module uart_rx #(
    parameter int CLKS_PER_BIT = 195
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] MID_CNT  = 8'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        CLEANUP      = 3'd4,
        WAIT_HIGH    = 3'd5
    } state_t;

    state_t     state;
    logic       rx_meta;
    logic       rx_s;
    logic       rx_samp;
    logic [7:0] count;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;

    // Two-stage synchronizer; resets to the idle (high) level.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] history;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            history <= 3'b111;
        end else begin
            history <= {history[1:0], rx_s};
        end
    end

    assign rx_samp = (history[0] & history[1]) |
                     (history[0] & history[2]) |
                     (history[1] & history[2]);
`else
    assign rx_samp = rx_s;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= IDLE;
            count       <= 8'd0;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'd0;
            o_RX_DV     <= 1'b0;
            o_RX_Byte   <= 8'd0;
            o_RX_Active <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;

            case (state)
                IDLE: begin
                    count   <= 8'd0;
                    bit_idx <= 3'd0;
                    if (!rx_s) begin
                        state <= RX_START_BIT;
                    end
                end

                RX_START_BIT: begin
                    if (count == MID_CNT) begin
                        count <= 8'd0;
                        if (!rx_samp) begin
                            o_RX_Active <= 1'b1;
                            state       <= RX_DATA_BITS;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end

                RX_DATA_BITS: begin
                    if (count == LAST_CNT) begin
                        count              <= 8'd0;
                        shift_reg[bit_idx] <= rx_samp;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            state   <= RX_STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end

                RX_STOP_BIT: begin
                    if (count == LAST_CNT) begin
                        count <= 8'd0;
                        if (rx_samp) begin
                            o_RX_Byte <= shift_reg;
                            o_RX_DV   <= 1'b1;
                            state     <= CLEANUP;
                        end else begin
                            o_Frame_Err <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end

                // Leaving after one cycle lets the remaining half stop bit
                // pass in IDLE, so a back-to-back start edge is not missed.
                CLEANUP: begin
                    o_RX_Active <= 1'b0;
                    state       <= IDLE;
                end

                // A held-low line (break) stays here, giving one error only.
                WAIT_HIGH: begin
                    if (rx_s) begin
                        o_RX_Active <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    o_RX_Active <= 1'b0;
                    count       <= 8'd0;
                    bit_idx     <= 3'd0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
